dmem_arbiter: RTL and testbench

Two-master arbiter and burst sequencer for the single-port 64-word data memory. It shares the memory between the core load/store unit (master 0) and the debug/DMA loader (master 1) using round-robin arbitration. Each accepted request is a 1–4 word burst, which the block expands into per-cycle memory read/write strobes with auto-incremented word addresses. Read data is returned registered; bad requests get an error response.

---
 rtl/dmem_pkg.sv | 15 +
 rtl/rr_arbiter2.sv | 18 +
 rtl/dmem_arbiter.sv | 179 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter slice.
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE,
      BURST,
      ERR
   } state_e;

   localparam int DMEM_DEPTH = 64;
   localparam int LEN_W      = 2;

   typedef logic mid_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: a lone requester wins, on contention the
// master that was not served last wins.
module rr_arbiter2
   import dmem_pkg::*;
(
   input  logic [1:0] req_i,
   input  mid_t       last_served_i,
   output mid_t       winner_o,
   output logic       valid_o
);

   // Winner select; valid whenever anyone is requesting.
   always_comb begin
      valid_o  = |req_i;
      winner_o = (req_i == 2'b11) ? ~last_served_i : req_i[1];
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the load/store unit (m0)
// and the debug/DMA loader (m1), expanding each grant into a 1-4 beat burst
// of memory strobes and returning read data one cycle after each read beat.
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int DEPTH = DMEM_DEPTH,
   parameter int DW    = 32,
   parameter int AW    = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             m0_req,
   input  logic             m0_we,
   input  logic [AW-1:0]    m0_addr,
   input  logic [LEN_W-1:0] m0_len,
   input  logic [DW-1:0]    m0_wdata,
   output logic             m0_ack,
   output logic             m0_last,
   output logic             m0_err,
   output logic             m0_rvalid,
   output logic [DW-1:0]    m0_rdata,
   input  logic             m1_req,
   input  logic             m1_we,
   input  logic [AW-1:0]    m1_addr,
   input  logic [LEN_W-1:0] m1_len,
   input  logic [DW-1:0]    m1_wdata,
   output logic             m1_ack,
   output logic             m1_last,
   output logic             m1_err,
   output logic             m1_rvalid,
   output logic [DW-1:0]    m1_rdata,
   output logic             mem_we,
   output logic             mem_re,
   output logic [AW-1:0]    mem_addr,
   output logic [DW-1:0]    mem_wdata,
   input  logic [DW-1:0]    mem_rdata,
   output logic             busy
);

   state_e           state_q, state_d;
   mid_t             last_q, last_d;
   mid_t             id_q, id_d;
   logic             we_q, we_d;
   logic [AW-3:0]    base_q, base_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] beat_q, beat_d;
   logic [1:0]       rvalid_q, rvalid_d;
   logic [DW-1:0]    rdata0_q, rdata1_q;

   mid_t             win;
   logic             win_vld;
   logic             sel_we;
   logic [AW-1:0]    sel_addr;
   logic [LEN_W-1:0] sel_len;
   logic             sel_err;
   logic [1:0]       ack, last, err;

   rr_arbiter2 u_arb (
      .req_i         ({m1_req, m0_req}),
      .last_served_i (last_q),
      .winner_o      (win),
      .valid_o       (win_vld)
   );

   // Request fields of the arbitration winner and its legality check; the
   // end word is computed one bit wider so it cannot wrap.
   always_comb begin
      sel_we   = win ? m1_we   : m0_we;
      sel_addr = win ? m1_addr : m0_addr;
      sel_len  = win ? m1_len  : m0_len;
      sel_err  = (sel_addr[1:0] != 2'b00) ||
                 (({1'b0, sel_addr[AW-1:2]} + (AW-1)'(sel_len)) > (AW-1)'(DEPTH - 1));
   end

   // Next state: capture on grant in IDLE, count beats in BURST.
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      id_d    = id_q;
      we_d    = we_q;
      base_d  = base_q;
      len_d   = len_q;
      beat_d  = beat_q;
      unique case (state_q)
         IDLE: begin
            if (win_vld) begin
               last_d  = win;
               id_d    = win;
               we_d    = sel_we;
               base_d  = sel_addr[AW-1:2];
               len_d   = sel_len;
               beat_d  = '0;
               state_d = sel_err ? ERR : BURST;
            end
         end
         BURST: begin
            if (beat_q == len_q) begin
               beat_d  = '0;
               state_d = IDLE;
            end else begin
               beat_d  = beat_q + 1'b1;
            end
         end
         ERR:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Per-master handshake and memory strobes, all zero outside BURST/ERR.
   always_comb begin
      ack       = '0;
      last      = '0;
      err       = '0;
      mem_we    = 1'b0;
      mem_re    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (state_q == BURST) begin
         ack[id_q]  = 1'b1;
         last[id_q] = (beat_q == len_q);
         mem_we     = we_q;
         mem_re     = !we_q;
         mem_addr   = {2'b00, base_q + (AW-2)'(beat_q)};
         mem_wdata  = id_q ? m1_wdata : m0_wdata;
      end else if (state_q == ERR) begin
         ack[id_q]  = 1'b1;
         last[id_q] = 1'b1;
         err[id_q]  = 1'b1;
      end
   end

   // Read return fires for the owner of each read beat.
   always_comb begin
      rvalid_d    = '0;
      rvalid_d[0] = (state_q == BURST) && !we_q && (id_q == 1'b0);
      rvalid_d[1] = (state_q == BURST) && !we_q && (id_q == 1'b1);
   end

   // State, capture and read-return registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         last_q   <= 1'b1;
         id_q     <= 1'b0;
         we_q     <= 1'b0;
         base_q   <= '0;
         len_q    <= '0;
         beat_q   <= '0;
         rvalid_q <= '0;
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else begin
         state_q  <= state_d;
         last_q   <= last_d;
         id_q     <= id_d;
         we_q     <= we_d;
         base_q   <= base_d;
         len_q    <= len_d;
         beat_q   <= beat_d;
         rvalid_q <= rvalid_d;
         if (rvalid_d[0]) rdata0_q <= mem_rdata;
         if (rvalid_d[1]) rdata1_q <= mem_rdata;
      end
   end

   assign m0_ack    = ack[0];
   assign m0_last   = last[0];
   assign m0_err    = err[0];
   assign m0_rvalid = rvalid_q[0];
   assign m0_rdata  = rdata0_q;
   assign m1_ack    = ack[1];
   assign m1_last   = last[1];
   assign m1_err    = err[1];
   assign m1_rvalid = rvalid_q[1];
   assign m1_rdata  = rdata1_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: per-cycle vector table plus hand-written
// reset-in-burst sequences, against a 64-word behavioural memory.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        m0_req, m0_we, m1_req, m1_we;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic [1:0]  m0_len, m1_len;
   logic        m0_ack, m0_last, m0_err, m0_rvalid;
   logic        m1_ack, m1_last, m1_err, m1_rvalid;
   logic [31:0] m0_rdata, m1_rdata;
   logic        mem_we, mem_re, busy;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   logic [31:0] mem [64];
   logic        mem_init;

   int n_run  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   dmem_arbiter dut (
      .clk       (clk),
      .reset     (reset),
      .m0_req    (m0_req),
      .m0_we     (m0_we),
      .m0_addr   (m0_addr),
      .m0_len    (m0_len),
      .m0_wdata  (m0_wdata),
      .m0_ack    (m0_ack),
      .m0_last   (m0_last),
      .m0_err    (m0_err),
      .m0_rvalid (m0_rvalid),
      .m0_rdata  (m0_rdata),
      .m1_req    (m1_req),
      .m1_we     (m1_we),
      .m1_addr   (m1_addr),
      .m1_len    (m1_len),
      .m1_wdata  (m1_wdata),
      .m1_ack    (m1_ack),
      .m1_last   (m1_last),
      .m1_err    (m1_err),
      .m1_rvalid (m1_rvalid),
      .m1_rdata  (m1_rdata),
      .mem_we    (mem_we),
      .mem_re    (mem_re),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .busy      (busy)
   );

   // Behavioural single-port memory: sync write, combinational read.
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 64; i++) mem[i] <= 32'h1000 + i;
      end else if (mem_we) begin
         mem[mem_addr[5:0]] <= mem_wdata;
      end
   end
   assign mem_rdata = mem[mem_addr[5:0]];

   typedef struct {
      logic        r0, we0;
      logic [31:0] a0;
      logic [1:0]  l0;
      logic [31:0] wd0;
      logic        r1, we1;
      logic [31:0] a1;
      logic [1:0]  l1;
      logic [31:0] wd1;
      logic [3:0]  x0;   // {ack,last,err,rvalid}
      logic [31:0] rd0;
      logic [3:0]  x1;
      logic [31:0] rd1;
      logic        mwe, mre;
      logic [31:0] maddr, mwd;
      logic        bsy;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(
      input logic [31:0] r0, we0, a0, l0, wd0,
      input logic [31:0] r1, we1, a1, l1, wd1,
      input logic [31:0] x0, rd0, x1, rd1,
      input logic [31:0] mwe, mre, maddr, mwd, bsy);
      vec_t v;
      v.r0 = r0[0]; v.we0 = we0[0]; v.a0 = a0; v.l0 = l0[1:0]; v.wd0 = wd0;
      v.r1 = r1[0]; v.we1 = we1[0]; v.a1 = a1; v.l1 = l1[1:0]; v.wd1 = wd1;
      v.x0 = x0[3:0]; v.rd0 = rd0; v.x1 = x1[3:0]; v.rd1 = rd1;
      v.mwe = mwe[0]; v.mre = mre[0]; v.maddr = maddr; v.mwd = mwd; v.bsy = bsy[0];
      return v;
   endfunction

   task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
      end
   endtask

   task automatic apply(input vec_t v);
      m0_req = v.r0; m0_we = v.we0; m0_addr = v.a0; m0_len = v.l0; m0_wdata = v.wd0;
      m1_req = v.r1; m1_we = v.we1; m1_addr = v.a1; m1_len = v.l1; m1_wdata = v.wd1;
   endtask

   task automatic check_row(input int i, input vec_t v);
      chk("m0_flags", i, {28'b0, m0_ack, m0_last, m0_err, m0_rvalid}, {28'b0, v.x0});
      chk("m1_flags", i, {28'b0, m1_ack, m1_last, m1_err, m1_rvalid}, {28'b0, v.x1});
      if (v.x0[0]) chk("m0_rdata", i, m0_rdata, v.rd0);
      if (v.x1[0]) chk("m1_rdata", i, m1_rdata, v.rd1);
      chk("mem_we_re", i, {30'b0, mem_we, mem_re}, {30'b0, v.mwe, v.mre});
      chk("mem_addr", i, mem_addr, v.maddr);
      chk("mem_wdata", i, mem_wdata, v.mwd);
      chk("busy", i, {31'b0, busy}, {31'b0, v.bsy});
   endtask

   initial begin
      // Contention straight after reset: m0, m1, m0, m1 (reads of words 8 / 16).
      vecs.push_back(mk(1,0,'h20,0,0, 1,0,'h40,0,0, 0,0,       0,0,       0,0,0,0,0));
      vecs.push_back(mk(1,0,'h20,0,0, 1,0,'h40,0,0, 'hC,0,     0,0,       0,1,8,0,1));
      vecs.push_back(mk(1,0,'h20,0,0, 1,0,'h40,0,0, 1,'h1008,  0,0,       0,0,0,0,0));
      vecs.push_back(mk(1,0,'h20,0,0, 1,0,'h40,0,0, 0,0,       'hC,0,     0,1,16,0,1));
      vecs.push_back(mk(1,0,'h20,0,0, 1,0,'h40,0,0, 0,0,       1,'h1010,  0,0,0,0,0));
      vecs.push_back(mk(1,0,'h20,0,0, 1,0,'h40,0,0, 'hC,0,     0,0,       0,1,8,0,1));
      vecs.push_back(mk(0,0,'h20,0,0, 1,0,'h40,0,0, 1,'h1008,  0,0,       0,0,0,0,0));
      vecs.push_back(mk(0,0,'h20,0,0, 1,0,'h40,0,0, 0,0,       'hC,0,     0,1,16,0,1));
      vecs.push_back(mk(0,0,'h20,0,0, 0,0,'h40,0,0, 0,0,       1,'h1010,  0,0,0,0,0));
      // m0 4-beat write at 0x10 then 4-beat read back.
      vecs.push_back(mk(1,1,'h10,3,'hA0, 0,0,0,0,0, 0,0,       0,0,       0,0,0,0,0));
      vecs.push_back(mk(1,1,'h10,3,'hA0, 0,0,0,0,0, 8,0,       0,0,       1,0,4,'hA0,1));
      vecs.push_back(mk(1,1,'h10,3,'hA1, 0,0,0,0,0, 8,0,       0,0,       1,0,5,'hA1,1));
      vecs.push_back(mk(1,1,'h10,3,'hA2, 0,0,0,0,0, 8,0,       0,0,       1,0,6,'hA2,1));
      vecs.push_back(mk(1,1,'h10,3,'hA3, 0,0,0,0,0, 'hC,0,     0,0,       1,0,7,'hA3,1));
      vecs.push_back(mk(1,0,'h10,3,0,    0,0,0,0,0, 0,0,       0,0,       0,0,0,0,0));
      vecs.push_back(mk(1,0,'h10,3,0,    0,0,0,0,0, 8,0,       0,0,       0,1,4,0,1));
      vecs.push_back(mk(1,0,'h10,3,0,    0,0,0,0,0, 9,'hA0,    0,0,       0,1,5,0,1));
      vecs.push_back(mk(1,0,'h10,3,0,    0,0,0,0,0, 9,'hA1,    0,0,       0,1,6,0,1));
      vecs.push_back(mk(1,0,'h10,3,0,    0,0,0,0,0, 'hD,'hA2,  0,0,       0,1,7,0,1));
      vecs.push_back(mk(0,0,'h10,3,0,    0,0,0,0,0, 1,'hA3,    0,0,       0,0,0,0,0));
      // m1 read past the end (word 63 + 1): error, no access.
      vecs.push_back(mk(0,0,0,0,0, 1,0,'hFC,1,0, 0,0,          0,0,       0,0,0,0,0));
      vecs.push_back(mk(0,0,0,0,0, 1,0,'hFC,1,0, 0,0,          'hE,0,     0,0,0,0,1));
      vecs.push_back(mk(0,0,0,0,0, 0,0,'hFC,1,0, 0,0,          0,0,       0,0,0,0,0));
      // m0 misaligned write: error, no access.
      vecs.push_back(mk(1,1,'h06,0,0, 0,0,0,0,0, 0,0,          0,0,       0,0,0,0,0));
      vecs.push_back(mk(1,1,'h06,0,0, 0,0,0,0,0, 'hE,0,        0,0,       0,0,0,0,1));
      vecs.push_back(mk(0,1,'h06,0,0, 0,0,0,0,0, 0,0,          0,0,       0,0,0,0,0));
      // m1 4-beat write ending exactly at word 63.
      vecs.push_back(mk(0,0,0,0,0, 1,1,'hF0,3,'hB0, 0,0,       0,0,       0,0,0,0,0));
      vecs.push_back(mk(0,0,0,0,0, 1,1,'hF0,3,'hB0, 0,0,       8,0,       1,0,60,'hB0,1));
      vecs.push_back(mk(0,0,0,0,0, 1,1,'hF0,3,'hB1, 0,0,       8,0,       1,0,61,'hB1,1));
      vecs.push_back(mk(0,0,0,0,0, 1,1,'hF0,3,'hB2, 0,0,       8,0,       1,0,62,'hB2,1));
      vecs.push_back(mk(0,0,0,0,0, 1,1,'hF0,3,'hB3, 0,0,       'hC,0,     1,0,63,'hB3,1));
      vecs.push_back(mk(0,0,0,0,0, 0,1,'hF0,3,0,    0,0,       0,0,       0,0,0,0,0));
      // m0 holds req across two 1-beat reads of word 63.
      vecs.push_back(mk(1,0,'hFC,0,0, 0,0,0,0,0, 0,0,          0,0,       0,0,0,0,0));
      vecs.push_back(mk(1,0,'hFC,0,0, 0,0,0,0,0, 'hC,0,        0,0,       0,1,63,0,1));
      vecs.push_back(mk(1,0,'hFC,0,0, 0,0,0,0,0, 1,'hB3,       0,0,       0,0,0,0,0));
      vecs.push_back(mk(1,0,'hFC,0,0, 0,0,0,0,0, 'hC,0,        0,0,       0,1,63,0,1));
      vecs.push_back(mk(0,0,'hFC,0,0, 0,0,0,0,0, 1,'hB3,       0,0,       0,0,0,0,0));

      reset = 1'b1; mem_init = 1'b1;
      m0_req = 0; m0_we = 0; m0_addr = 0; m0_len = 0; m0_wdata = 0;
      m1_req = 0; m1_we = 0; m1_addr = 0; m1_len = 0; m1_wdata = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_flags", 0, {24'b0, m0_ack, m0_last, m0_err, m0_rvalid, m1_ack, m1_last, m1_err, m1_rvalid}, 32'h0);
      chk("rst_mem", 0, {30'b0, mem_we, mem_re} | mem_addr | mem_wdata, 32'h0);
      chk("rst_rdata", 0, m0_rdata | m1_rdata, 32'h0);
      chk("rst_busy", 0, {31'b0, busy}, 32'h0);
      reset = 1'b0; mem_init = 1'b0;

      foreach (vecs[i]) begin
         @(posedge clk); #1;
         apply(vecs[i]);
         #3;
         check_row(i, vecs[i]);
      end

      chk("mem_w4", 0, mem[4], 32'hA0);
      chk("mem_w7", 0, mem[7], 32'hA3);
      chk("mem_w60", 0, mem[60], 32'hB0);
      chk("mem_w63", 0, mem[63], 32'hB3);
      chk("mem_w1_untouched", 0, mem[1], 32'h1001);

      // Reset during beat 2 of a 4-beat write to word 32.
      @(posedge clk); #1;
      m0_req = 1; m0_we = 1; m0_addr = 'h80; m0_len = 3; m0_wdata = 'hC0;
      @(posedge clk); #1;
      chk("rb_beat0_addr", 100, mem_addr, 32);
      @(posedge clk); #1; m0_wdata = 'hC1;
      @(posedge clk); #1; m0_wdata = 'hC2;
      #1 reset = 1'b1;
      #1;
      chk("rb_ack", 101, {31'b0, m0_ack}, 32'h0);
      chk("rb_mem_we", 101, {31'b0, mem_we}, 32'h0);
      chk("rb_busy", 101, {31'b0, busy}, 32'h0);
      chk("rb_rdata_cleared", 101, m0_rdata, 32'h0);
      m0_req = 0;
      @(posedge clk); #1 reset = 1'b0;
      @(posedge clk); #1;
      chk("rb_mem32", 102, mem[32], 32'hC0);
      chk("rb_mem33", 102, mem[33], 32'hC1);
      chk("rb_mem34", 102, mem[34], 32'h1022);
      chk("rb_mem35", 102, mem[35], 32'h1023);

      // Reset during a read beat drops the pending rvalid.
      m1_req = 1; m1_we = 0; m1_addr = 'h08; m1_len = 0; m1_wdata = 0;
      @(posedge clk); #1;
      chk("rr_ack", 103, {31'b0, m1_ack}, 32'h1);
      reset = 1'b1; m1_req = 0;
      @(posedge clk); #1;
      chk("rr_rvalid_lost", 104, {31'b0, m1_rvalid}, 32'h0);
      reset = 1'b0;
      @(posedge clk); #1;
      chk("rr_idle", 105, {30'b0, m1_rvalid, busy}, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
